// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential shift-and-add-3 (double-dabble) converter. Turns an unsigned
// WIDTH-bit binary value into three BCD digits (hundreds, tens, ones) for the
// 3-digit seven-segment scanner. One iteration runs per clock. A conversion
// takes WIDTH cycles after the accept edge.
//
// Handshake:
//   An accept happens on a rising edge where in_valid && in_ready.
//   in_ready is high only in IDLE. in_valid is ignored while a conversion is
//   running. done pulses for one cycle in the cycle in which new digits first
//   appear. in_ready is already high in that cycle, so the next value can be
//   accepted on the following edge.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      synchronous active-high reset
//   bin_in   in   WIDTH  value to convert, sampled on the accept edge only
//   in_valid in   1      request to convert bin_in
//   in_ready out  1      block can accept a new value (state == IDLE)
//   digit0   out  4      ones digit, registered
//   digit1   out  4      tens digit, registered
//   digit2   out  4      hundreds digit, registered
//   done     out  1      one-cycle completion pulse
//
// Parameter:
//   WIDTH    legal range is 1..9, so that 2^WIDTH-1 fits in three digits.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic             done
);

  // The working register is {hundreds, tens, ones, bin}.
  localparam int W  = 12 + WIDTH;
  localparam int CW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    work;
  logic [W-1:0]    adj;
  logic [W-1:0]    shifted;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic and control decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // The counter reaching 1 marks the final iteration.
        if (cnt == CW'(1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Add-3 correction on the pre-shift nibbles. The shift is applied to the
  // corrected value in the same cycle.
  always_comb begin
    adj = work;
    for (int i = 0; i < 3; i++) begin
      if (work[WIDTH + 4*i +: 4] >= 4'd5) begin
        adj[WIDTH + 4*i +: 4] = work[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = adj << 1;

  // Datapath. The digit registers change only on completion or on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      cnt    <= '0;
      digit0 <= 4'd0;
      digit1 <= 4'd0;
      digit2 <= 4'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        work <= {12'd0, bin_in};
        cnt  <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        work <= shifted;
        cnt  <= cnt - CW'(1);
        if (last) begin
          digit2 <= shifted[W-1 -: 4];
          digit1 <= shifted[W-5 -: 4];
          digit0 <= shifted[WIDTH +: 4];
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Bench for bin2bcd_seq at WIDTH = 8. A table of hand-computed vectors is
// followed by an exhaustive 0..255 sweep against a divide/modulo model. Then
// come hand-written sequences for back-to-back accepts, in_valid during SHIFT,
// reset mid-conversion, and reset coinciding with in_valid.
// Inputs are driven and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int WIDTH = 8;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] bin_in;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       digit0;
  logic [3:0]       digit1;
  logic [3:0]       digit2;
  logic             done;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .done     (done)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0] value;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [11:0] digits();
    return {digit2, digit1, digit0};
  endfunction

  // driver: present a value for one accept edge. This starts and ends at a
  // falling edge, and it ends on the first falling edge after the accept.
  task automatic start(input logic [7:0] v);
    check("ready_before_accept", 32'(in_ready), 32'd1);
    bin_in   = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for done. lat counts rising edges after the accept edge. busy counts
  // samples with in_ready low. held is cleared if the digits move before done.
  task automatic wait_done(output int lat, output int busy, output bit held);
    logic [11:0] prev;
    prev = digits();
    lat  = 0;
    busy = 0;
    held = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (in_ready === 1'b0) busy++;
      if (digits() !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_check(input string name);
    logic [11:0] e;
    e = exp_q.pop_front();
    check(name, 32'(digits()), 32'(e));
  endtask

  initial begin
    int lat;
    int busy;
    bit held;
    int gap;
    int seen;

    vecs[0] = '{8'd123, 4'd1, 4'd2, 4'd3};
    vecs[1] = '{8'd0,   4'd0, 4'd0, 4'd0};
    vecs[2] = '{8'd9,   4'd0, 4'd0, 4'd9};
    vecs[3] = '{8'd10,  4'd0, 4'd1, 4'd0};
    vecs[4] = '{8'd99,  4'd0, 4'd9, 4'd9};
    vecs[5] = '{8'd100, 4'd1, 4'd0, 4'd0};
    vecs[6] = '{8'd255, 4'd2, 4'd5, 4'd5};

    // reset
    rst      = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_digits", 32'(digits()), 32'h000);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({vecs[i].d2, vecs[i].d1, vecs[i].d0});
      start(vecs[i].value);
      wait_done(lat, busy, held);
      check("table_latency", 32'(lat), 32'd8);
      check("table_busy", 32'(busy), 32'd8);
      pop_check("table_digits");
      @(negedge clk);
      check("table_done_pulse", 32'(done), 32'd0);
      check("table_digits_stable", 32'(digits()),
            32'({vecs[i].d2, vecs[i].d1, vecs[i].d0}));
    end

    // exhaustive sweep against the divide/modulo model
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back({4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
      start(8'(v));
      wait_done(lat, busy, held);
      check("sweep_latency", 32'(lat), 32'd8);
      pop_check("sweep_digits");
    end

    // back-to-back with in_valid held high: 200, then 7
    @(negedge clk);
    check("b2b_ready", 32'(in_ready), 32'd1);
    bin_in   = 8'd200;
    in_valid = 1'b1;
    @(negedge clk);
    bin_in   = 8'd7;
    wait_done(lat, busy, held);
    check("b2b_first_latency", 32'(lat), 32'd8);
    check("b2b_first_digits", 32'(digits()), 32'h200);
    check("b2b_ready_in_done", 32'(in_ready), 32'd1);
    // in_valid stays high through the edge that closes the done cycle
    @(negedge clk);
    in_valid = 1'b0;
    gap = 1;
    check("b2b_second_busy", 32'(in_ready), 32'd0);
    while (done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_done_gap", 32'(gap), 32'd9);
    check("b2b_second_digits", 32'(digits()), 32'h007);

    // establish 123, then start 45 and poke 250 two cycles into SHIFT
    @(negedge clk);
    start(8'd123);
    wait_done(lat, busy, held);
    check("pre_123_digits", 32'(digits()), 32'h123);
    @(negedge clk);
    start(8'd45);
    @(negedge clk);
    @(negedge clk);
    bin_in   = 8'd250;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("ignore_hold_mid", 32'(digits()), 32'h123);
    wait_done(lat, busy, held);
    check("ignore_latency_rest", 32'(lat), 32'd5);
    check("ignore_digits_held", 32'(held), 32'd1);
    check("ignore_digits", 32'(digits()), 32'h045);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("ignore_no_extra_done", 32'(seen), 32'd0);
    check("ignore_digits_final", 32'(digits()), 32'h045);

    // reset four cycles into a conversion of 255
    start(8'd255);
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_digits", 32'(digits()), 32'h000);
    check("abort_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    start(8'd42);
    wait_done(lat, busy, held);
    check("abort_fresh_latency", 32'(lat), 32'd8);
    check("abort_fresh_digits", 32'(digits()), 32'h042);

    // reset and in_valid together: nothing is accepted
    @(negedge clk);
    rst      = 1'b1;
    bin_in   = 8'd99;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_wins_ready", 32'(in_ready), 32'd1);
    check("rst_wins_digits", 32'(digits()), 32'h000);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check("rst_wins_no_done", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter. Turns an unsigned binary value into three BCD digits (hundreds, tens, ones).
- Sits directly upstream of the 3-digit seven-segment scanner. Its digit0/digit1/digit2 outputs drive the scanner's digit inputs one-to-one.
- Uses a valid/ready input handshake and a done pulse.
- Digit outputs are registered. They hold the last completed result, so the display never shows partial conversions.

Parameters:
- WIDTH, 8, bit width of the binary input. Legal range is 1..9, because 2^WIDTH-1 must not exceed 999. Values outside this range are unsupported.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- bin_in  input  WIDTH  unsigned value to convert; sampled on the accept edge only.
- in_valid  input  1  request to convert bin_in.
- in_ready  output  1  high when the block can accept a new value.
- digit0  output  4  ones digit (BCD 0-9), registered.
- digit1  output  4  tens digit (BCD 0-9), registered.
- digit2  output  4  hundreds digit (BCD 0-9), registered.
- done  output  1  one-cycle pulse; asserted in the cycle in which new digits first appear.

Behaviour:
- Reset: rst is sampled on the rising edge of clk; there is no asynchronous path. On reset:
  - digit0 = digit1 = digit2 = 0, done = 0, state = IDLE, in_ready = 1.
  - Internal shift register and iteration counter are cleared.
- States: IDLE and SHIFT. in_ready = (state == IDLE), decoded combinationally from the state register.
- Accept: an edge with in_valid = 1 and in_ready = 1 is an accept edge.
  - bin_in is latched into the shift register (BCD field cleared to 0).
  - The iteration counter is loaded with WIDTH.
  - State goes to SHIFT.
  - in_valid while in SHIFT is ignored: nothing is latched and no error is flagged.
- SHIFT iteration, one per clock:
  - Each BCD nibble of the working register that is >= 5 gets +3.
  - The whole {bcd, bin} register is then shifted left by 1.
  - The counter decrements.
  - The add-3 and the shift happen in the same cycle, on the pre-shift nibble values.
- Completion, on the edge where the counter goes from 1 to 0:
  - digit2/digit1/digit0 are loaded with the final BCD nibbles.
  - done = 1 for exactly one cycle.
  - State returns to IDLE.
- Latency: accept at edge T; digits updated and done high after edge T+WIDTH. For WIDTH = 8, that is 8 cycles after accept.
- Throughput:
  - in_ready is high in the same cycle done is high.
  - A new accept is legal on edge T+WIDTH+1, giving one conversion per WIDTH+1 cycles back-to-back.
- Output hold:
  - The digit registers change only on a completion edge or on reset.
  - During SHIFT they hold the previous result.
- Width rules:
  - Working register is 12 + WIDTH bits.
  - Unused hundreds bits stay 0 for small WIDTH. Example: WIDTH = 4 gives max value 15, so digit2 = 0.
  - Digits never exceed 9 for any legal WIDTH.
- Boundaries:
  - bin_in = 0 produces 0,0,0 with full latency, and still pulses done.
  - Maximum input (255 at WIDTH = 8) produces 2,5,5.
- Reset mid-conversion:
  - Aborts immediately; no done pulse is produced.
  - Digits are cleared to 0 and in_ready = 1 on the next cycle.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.

Test Plan:
- Reset, then in_valid = 1 for one cycle with bin_in = 8'd123:
  - in_ready is low for 8 cycles.
  - done pulses once, 8 cycles after accept.
  - digit2,1,0 = 1,2,3 and stay stable afterwards.
- Sweep bin_in over 0, 9, 10, 99, 100, 255, one conversion each:
  - digits = 000, 009, 010, 099, 100, 255.
  - digit2 = 0 for values < 100.
  - Exhaustive 0..255 compared against a value/100, value/10%10, value%10 model.
- Back-to-back, in_valid held high, bin_in = 200 then 7 on the next accept:
  - The second accept occurs in the done cycle of the first.
  - Results are 2,0,0 then 0,0,7.
  - Exactly 9 cycles between the two done pulses.
- Start bin_in = 45; two cycles into SHIFT, drive in_valid = 1 with bin_in = 250:
  - Result is 0,4,5.
  - 250 is never captured.
  - Digits hold the previous result (e.g. 1,2,3) until the done edge.
- Start bin_in = 255; assert rst 4 cycles into SHIFT:
  - No done pulse occurs.
  - Digits = 0,0,0 and in_ready = 1 the cycle after reset.
  - A fresh conversion of 42 then yields 0,4,2.
